uart_tx: RTL and testbench

Serial UART transmitter that is the counterpart of the team's UART receiver. It accepts one byte per valid/ready handshake and shifts out one frame on `tx`: start bit, 8 data bits LSB first, an optional parity bit, and 1 or 2 stop bits. A programmable clock divider sets the bit period. It sits between the parallel data producer and the serial pin, and its frame format matches the receiver's state sequence: start, data, parity slot, stop.

---
 rtl/uart_tx.sv | 130 +++++++++++++
 tb/tb_uart_tx.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx.sv
// rtl/uart_tx.sv - UART transmitter: start, 8 data bits LSB first, optional parity, 1 or 2 stop bits
module uart_tx #(
  parameter int CLKS_PER_BIT = 16,
  parameter int PARITY_EN    = 1,
  parameter int PARITY_ODD   = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       tx,
  output logic       busy,
  output logic       done
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  localparam logic [15:0] DIV_LAST  = 16'(CLKS_PER_BIT - 1);
  localparam logic [2:0]  STOP_LAST = 3'(STOP_BITS - 1);

  state_t      state_q, state_d;
  logic [15:0] div_q, div_d;
  logic [2:0]  bit_q, bit_d;
  logic [7:0]  shreg_q, shreg_d;
  logic        par_q, par_d;
  logic        tx_d, ready_d, busy_d, done_d;
  logic        tick;

  assign tick = (div_q == DIV_LAST);

  always_comb begin
    state_d = state_q;
    div_d   = tick ? 16'd0 : div_q + 16'd1;
    bit_d   = bit_q;
    shreg_d = shreg_q;
    par_d   = par_q;
    done_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        div_d = 16'd0;
        if (tx_valid) begin
          shreg_d = tx_data;
          par_d   = (^tx_data) ^ (PARITY_ODD != 0);
          state_d = S_START;
        end
      end
      S_START: begin
        if (tick) begin
          state_d = S_DATA;
          bit_d   = 3'd0;
        end
      end
      S_DATA: begin
        if (tick) begin
          shreg_d = shreg_q >> 1;
          if (bit_q == 3'd7) begin
            state_d = (PARITY_EN != 0) ? S_PARITY : S_STOP;
            bit_d   = 3'd0;
          end else begin
            bit_d = bit_q + 3'd1;
          end
        end
      end
      S_PARITY: begin
        if (tick) begin
          state_d = S_STOP;
          bit_d   = 3'd0;
        end
      end
      S_STOP: begin
        if (tick) begin
          if (bit_q == STOP_LAST) begin
            state_d = S_IDLE;
            bit_d   = 3'd0;
            done_d  = 1'b1;
          end else begin
            bit_d = bit_q + 3'd1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs are decoded from the next state so they register in step with it.
  always_comb begin
    tx_d = 1'b1;
    case (state_d)
      S_START:  tx_d = 1'b0;
      S_DATA:   tx_d = shreg_d[0];
      S_PARITY: tx_d = par_d;
      default:  tx_d = 1'b1;
    endcase
    ready_d = (state_d == S_IDLE);
    busy_d  = ~ready_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      div_q    <= 16'd0;
      bit_q    <= 3'd0;
      shreg_q  <= 8'd0;
      par_q    <= 1'b0;
      tx       <= 1'b1;
      tx_ready <= 1'b1;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      state_q  <= state_d;
      div_q    <= div_d;
      bit_q    <= bit_d;
      shreg_q  <= shreg_d;
      par_q    <= par_d;
      tx       <= tx_d;
      tx_ready <= ready_d;
      busy     <= busy_d;
      done     <= done_d;
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
// tb/tb_uart_tx.sv - self-checking bench for uart_tx across four frame formats
module tb_uart_tx;

  logic            clk;
  logic [3:0]      rst_n;
  logic [3:0][7:0] td;
  logic [3:0]      vld;
  logic [3:0]      rdy, txo, bsy, dn;

  int n_cmp = 0;
  int n_bad = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  uart_tx #(.CLKS_PER_BIT(4), .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(1)) u0 (
    .clk(clk), .rst_n(rst_n[0]), .tx_data(td[0]), .tx_valid(vld[0]),
    .tx_ready(rdy[0]), .tx(txo[0]), .busy(bsy[0]), .done(dn[0]));
  uart_tx #(.CLKS_PER_BIT(4), .PARITY_EN(1), .PARITY_ODD(1), .STOP_BITS(2)) u1 (
    .clk(clk), .rst_n(rst_n[1]), .tx_data(td[1]), .tx_valid(vld[1]),
    .tx_ready(rdy[1]), .tx(txo[1]), .busy(bsy[1]), .done(dn[1]));
  uart_tx #(.CLKS_PER_BIT(4), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(1)) u2 (
    .clk(clk), .rst_n(rst_n[2]), .tx_data(td[2]), .tx_valid(vld[2]),
    .tx_ready(rdy[2]), .tx(txo[2]), .busy(bsy[2]), .done(dn[2]));
  uart_tx #(.CLKS_PER_BIT(2), .PARITY_EN(1), .PARITY_ODD(1), .STOP_BITS(2)) u3 (
    .clk(clk), .rst_n(rst_n[3]), .tx_data(td[3]), .tx_valid(vld[3]),
    .tx_ready(rdy[3]), .tx(txo[3]), .busy(bsy[3]), .done(dn[3]));

  function automatic int cfg_c(input int i);
    return (i == 3) ? 2 : 4;
  endfunction
  function automatic int cfg_pe(input int i);
    return (i == 2) ? 0 : 1;
  endfunction
  function automatic int cfg_po(input int i);
    return (i == 1 || i == 3) ? 1 : 0;
  endfunction
  function automatic int cfg_s(input int i);
    return (i == 1 || i == 3) ? 2 : 1;
  endfunction
  function automatic int frame_len(input int i);
    return cfg_c(i) * (9 + cfg_pe(i) + cfg_s(i));
  endfunction

  // Reference line level for cycle k (1 = first cycle after the accepting edge).
  function automatic logic exp_bit(input int i, input logic [7:0] data, input int k);
    int slot;
    int ones;
    slot = (k - 1) / cfg_c(i);
    if (slot == 0) return 1'b0;
    if (slot <= 8) return data[slot-1];
    if (cfg_pe(i) == 1 && slot == 9) begin
      ones = 0;
      for (int b = 0; b < 8; b++) ones += int'(data[b]);
      return logic'((ones % 2) != cfg_po(i));
    end
    return 1'b1;
  endfunction

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic run_frame(input int idx, input logic [7:0] data, input bit hold,
                           input int mut_k, input logic [7:0] mut_v, input int abort_k,
                           output int bad, output int done_edge, output int slot9);
    int c, f, w;
    c = cfg_c(idx);
    f = frame_len(idx);
    bad = 0;
    done_edge = -1;
    slot9 = -1;
    w = 0;
    while (rdy[idx] !== 1'b1 && w < 200) begin
      @(posedge clk); #1;
      w++;
    end
    check("ready_wait", int'(rdy[idx] === 1'b1), 1);
    if (rdy[idx] !== 1'b1) return;
    td[idx]  = data;
    vld[idx] = 1'b1;
    @(posedge clk);
    for (int k = 1; k <= f + 1; k++) begin
      if (k > 1) @(posedge clk);
      #1;
      if (dn[idx] === 1'b1 && done_edge < 0) done_edge = k - 1;
      if (k == 9 * c + 1) slot9 = int'(txo[idx]);
      if (k <= f) begin
        if (txo[idx] !== exp_bit(idx, data, k)) bad++;
        if (rdy[idx] !== 1'b0 || bsy[idx] !== 1'b1 || dn[idx] !== 1'b0) bad++;
      end else begin
        if (txo[idx] !== 1'b1 || rdy[idx] !== 1'b1 || bsy[idx] !== 1'b0 || dn[idx] !== 1'b1) bad++;
      end
      if (k == 1 && !hold) vld[idx] = 1'b0;
      if (k == mut_k) td[idx] = mut_v;
      if (k == abort_k) begin
        rst_n[idx] = 1'b0;
        vld[idx]   = 1'b0;
        #1;
        check("rst_tx", int'(txo[idx]), 1);
        check("rst_busy", int'(bsy[idx]), 0);
        check("rst_ready", int'(rdy[idx]), 1);
        check("rst_done", int'(dn[idx]), 0);
        return;
      end
    end
    if (!hold) begin
      @(posedge clk); #1;
      if (dn[idx] !== 1'b0 || txo[idx] !== 1'b1) bad++;
    end
  endtask

  typedef struct {
    int         idx;
    logic [7:0] data;
    int         mut_k;
    logic [7:0] mut_v;
    int         exp_slot9;
    int         exp_done;
  } vec_t;

  vec_t vt [7];

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int bad, de, s9, idx, f, gap, mk;
    logic [7:0] d, mv;

    vt[0] = '{0, 8'hA5, 0,  8'h00, 0, 44};
    vt[1] = '{1, 8'h07, 0,  8'h00, 0, 48};
    vt[2] = '{2, 8'hFF, 0,  8'h00, 1, 40};
    vt[3] = '{0, 8'h55, 12, 8'hAA, 0, 44};
    vt[4] = '{1, 8'h00, 0,  8'h00, 1, 48};
    vt[5] = '{3, 8'h01, 0,  8'h00, 0, 24};
    vt[6] = '{3, 8'h00, 0,  8'h00, 1, 24};

    rst_n = '0;
    vld   = '0;
    td    = '0;
    repeat (3) @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++) begin
      check($sformatf("reset_tx%0d", i), int'(txo[i]), 1);
      check($sformatf("reset_ready%0d", i), int'(rdy[i]), 1);
      check($sformatf("reset_busy%0d", i), int'(bsy[i]), 0);
      check($sformatf("reset_done%0d", i), int'(dn[i]), 0);
    end
    rst_n = '1;

    repeat (20) @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++) begin
      check($sformatf("idle_tx%0d", i), int'(txo[i]), 1);
      check($sformatf("idle_busy%0d", i), int'(bsy[i]), 0);
    end

    for (int i = 0; i < 7; i++) begin
      @(posedge clk); #1;
      run_frame(vt[i].idx, vt[i].data, 1'b0, vt[i].mut_k, vt[i].mut_v, 0, bad, de, s9);
      check($sformatf("vec%0d_wave", i), bad, 0);
      check($sformatf("vec%0d_done", i), de, vt[i].exp_done);
      check($sformatf("vec%0d_slot9", i), s9, vt[i].exp_slot9);
    end

    // Back-to-back with tx_valid held high across the boundary.
    @(posedge clk); #1;
    run_frame(0, 8'h00, 1'b1, 0, 8'h00, 0, bad, de, s9);
    check("b2b_first_wave", bad, 0);
    check("b2b_first_done", de, 44);
    run_frame(0, 8'h80, 1'b0, 0, 8'h00, 0, bad, de, s9);
    check("b2b_second_wave", bad, 0);
    check("b2b_second_done", de, 44);
    check("b2b_second_par", s9, 1);

    // Reset ten cycles into a frame, then a clean frame right after release.
    @(posedge clk); #1;
    run_frame(0, 8'h96, 1'b0, 0, 8'h00, 10, bad, de, s9);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check("rst_hold_done", int'(dn[0]), 0);
      check("rst_hold_tx", int'(txo[0]), 1);
    end
    rst_n[0] = 1'b1;
    run_frame(0, 8'h3C, 1'b0, 0, 8'h00, 0, bad, de, s9);
    check("post_rst_wave", bad, 0);
    check("post_rst_done", de, 44);
    check("post_rst_par", s9, 0);

    for (int i = 0; i < 30; i++) begin
      idx = $urandom_range(0, 3);
      d   = 8'($urandom);
      f   = frame_len(idx);
      gap = $urandom_range(0, 3);
      mk  = ($urandom_range(0, 1) == 1) ? $urandom_range(2, f) : 0;
      mv  = 8'($urandom);
      repeat (gap) @(posedge clk);
      #1;
      run_frame(idx, d, 1'b0, mk, mv, 0, bad, de, s9);
      check($sformatf("rnd%0d_wave", i), bad, 0);
      check($sformatf("rnd%0d_done", i), de, f);
      check($sformatf("rnd%0d_slot9", i), s9, int'(exp_bit(idx, d, 9 * cfg_c(idx) + 1)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
